// File: rtl/sync_frame_tx.sv
// sync_frame_tx
//   Serial frame generator. Each frame is the 4-bit sync pattern (MSB first),
//   the payload word (MSB first), then GAP zero bits. One bit leaves per clock.
//
// Parameters
//   DATA_W   : payload width in bits (>= 1)
//   SYNC_PAT : 4-bit sync pattern, sent MSB first
//   GAP      : trailing zero bits per frame (>= 1)
//
// Ports
//   clk        : clock, all logic on posedge
//   reset      : synchronous, active-high; aborts any frame in flight
//   tx_data    : payload, sampled only on the handshake edge
//   tx_valid   : payload offered
//   tx_ready   : block can accept (high only in IDLE, decoded from state)
//   seq_out    : registered serial bit
//   busy       : frame in progress (SYNC, DATA or GAP)
//   frame_done : one-cycle pulse in the first IDLE cycle after GAP
//   dbg_state  : current FSM state, for observation only
//
// Handshake: a word transfers on a posedge where tx_valid && tx_ready.
// tx_ready depends on state only. tx_valid outside IDLE is ignored, so the
// sender must hold tx_valid until it sees tx_ready.

module sync_frame_tx #(
    parameter int         DATA_W   = 8,
    parameter logic [3:0] SYNC_PAT = 4'b1011,
    parameter int         GAP      = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              seq_out,
    output logic              busy,
    output logic              frame_done,
    output logic [1:0]        dbg_state
);

    generate
        if (DATA_W < 1) begin : g_bad_data_w
            $error("sync_frame_tx: DATA_W must be >= 1");
        end
        if (GAP < 1) begin : g_bad_gap
            $error("sync_frame_tx: GAP must be >= 1");
        end
    endgenerate

    // One counter serves every phase, so it must reach the longest phase.
    localparam int MAX_LEN = (DATA_W > GAP) ? ((DATA_W > 4) ? DATA_W : 4)
                                            : ((GAP > 4) ? GAP : 4);
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(3);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        GAPS = 2'd3
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] shreg_q;
    logic              seq_out_q;
    logic              frame_done_q;

    // seq_out_q always holds the bit of the cycle described by
    // (state_q, cnt_q). Inside SYNC the next bit to load therefore sits one
    // position below the current one: cnt 0,1,2 -> SYNC_PAT[2],[1],[0].
    logic [1:0] sync_next_idx;
    assign sync_next_idx = 2'd2 - cnt_q[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            seq_out_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    seq_out_q <= 1'b0;
                    cnt_q     <= '0;
                    if (tx_valid) begin
                        shreg_q   <= tx_data;
                        seq_out_q <= SYNC_PAT[3];
                        state_q   <= SYNC;
                    end
                end

                SYNC: begin
                    if (cnt_q == SYNC_LAST) begin
                        // First payload bit goes out now; shift so the
                        // register MSB is always the next bit to send.
                        seq_out_q <= shreg_q[DATA_W-1];
                        shreg_q   <= shreg_q << 1;
                        cnt_q     <= '0;
                        state_q   <= DATA;
                    end else begin
                        seq_out_q <= SYNC_PAT[sync_next_idx];
                        cnt_q     <= cnt_q + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt_q == DATA_LAST) begin
                        seq_out_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= GAPS;
                    end else begin
                        seq_out_q <= shreg_q[DATA_W-1];
                        shreg_q   <= shreg_q << 1;
                        cnt_q     <= cnt_q + 1'b1;
                    end
                end

                GAPS: begin
                    seq_out_q <= 1'b0;
                    if (cnt_q == GAP_LAST) begin
                        cnt_q        <= '0;
                        frame_done_q <= 1'b1;
                        state_q      <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                default: begin
                    seq_out_q <= 1'b0;
                    cnt_q     <= '0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign tx_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign seq_out    = seq_out_q;
    assign frame_done = frame_done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_sync_frame_tx.sv
module tb_sync_frame_tx;

    logic       clk;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       seq_out;
    logic       busy;
    logic       frame_done;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int fd_count = 0;
    int det_count = 0;

    sync_frame_tx #(
        .DATA_W   (8),
        .SYNC_PAT (4'b1011),
        .GAP      (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .seq_out    (seq_out),
        .busy       (busy),
        .frame_done (frame_done),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Moore 1011 detector (overlapping), registered output
    typedef enum logic [2:0] {D_S0, D_S1, D_S10, D_S101, D_HIT} det_t;
    det_t det_q;
    logic detect_out;

    always @(posedge clk) begin
        if (reset) begin
            det_q      <= D_S0;
            detect_out <= 1'b0;
        end else begin
            case (det_q)
                D_S0:    det_q <= seq_out ? D_S1   : D_S0;
                D_S1:    det_q <= seq_out ? D_S1   : D_S10;
                D_S10:   det_q <= seq_out ? D_S101 : D_S0;
                D_S101:  det_q <= seq_out ? D_HIT  : D_S10;
                D_HIT:   det_q <= seq_out ? D_S1   : D_S10;
                default: det_q <= D_S0;
            endcase
            detect_out <= (det_q == D_HIT);
        end
    end

    // event counters
    always @(posedge clk) begin
        if (!reset && frame_done) fd_count <= fd_count + 1;
        if (!reset && detect_out) det_count <= det_count + 1;
    end

    // checker
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver: one frame, handshake on the next posedge, checks cycles 1..15
    task automatic run_frame(input logic [7:0] data, input bit hold_valid,
                             input bit disturb, input bit chk_det);
        logic [13:0] exp_bits;
        int ready_low;
        exp_bits  = {4'b1011, data, 2'b00};
        ready_low = 0;
        tx_data   = data;
        tx_valid  = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_valid) tx_valid = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            if (disturb && c == 2) tx_data = ~data;
            if (disturb && (c == 3 || c == 9)) tx_valid = 1'b1;
            if (disturb && (c == 4 || c == 10)) tx_valid = 1'b0;
            @(negedge clk);
            if (c <= 14) begin
                check($sformatf("f%02h c%0d seq_out", data, c), seq_out, exp_bits[14-c]);
                check($sformatf("f%02h c%0d busy", data, c), busy, 1);
                check($sformatf("f%02h c%0d frame_done", data, c), frame_done, 0);
                if (!tx_ready) ready_low++;
            end else begin
                check($sformatf("f%02h end frame_done", data), frame_done, 1);
                check($sformatf("f%02h end tx_ready", data), tx_ready, 1);
                check($sformatf("f%02h end busy", data), busy, 0);
                check($sformatf("f%02h end seq_out", data), seq_out, 0);
            end
            if (chk_det)
                check($sformatf("f%02h c%0d detect_out", data, c), detect_out, (c == 6));
        end
        check($sformatf("f%02h tx_ready low cycles", data), ready_low, 14);
    endtask

    initial begin
        int fd0;
        int det0;

        // reset with tx_valid asserted
        reset    = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst seq_out", seq_out, 0);
            check("rst busy", busy, 0);
            check("rst frame_done", frame_done, 0);
            check("rst tx_ready", tx_ready, 1);
        end
        @(posedge clk);
        #1;
        reset    = 1'b0;
        tx_valid = 1'b0;
        @(negedge clk);
        check("post-rst busy", busy, 0);
        check("post-rst tx_ready", tx_ready, 1);

        // single frame
        run_frame(8'hA5, 0, 0, 0);
        @(negedge clk);
        check("A5 pulse width frame_done", frame_done, 0);
        check("A5 idle busy", busy, 0);

        // back-to-back with tx_valid held
        fd0 = fd_count;
        run_frame(8'h00, 1, 0, 0);
        run_frame(8'hFF, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        check("b2b frame_done count", fd_count - fd0, 2);

        // inputs toggled while busy
        run_frame(8'hC3, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("disturb no extra busy", busy, 0);
            check("disturb no extra tx_ready", tx_ready, 1);
        end

        // mid-frame reset in cycle 7
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("mid c7 busy", busy, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid-rst seq_out", seq_out, 0);
        check("mid-rst busy", busy, 0);
        check("mid-rst frame_done", frame_done, 0);
        check("mid-rst tx_ready", tx_ready, 1);
        fd0 = fd_count;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("mid-rst stays idle", busy, 0);
        end
        check("mid-rst no frame_done", fd_count - fd0, 0);
        run_frame(8'h3C, 0, 0, 0);

        // loopback into the 1011 detector
        @(negedge clk);
        det0 = det_count;
        for (int i = 0; i < 10; i++)
            run_frame((i % 2) ? 8'hFF : 8'h00, 0, 0, 1);
        @(negedge clk);
        check("loopback detect count", det_count - det0, 10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
